// File: rtl/cache_pkg.sv
// Shared cache definitions: block geometry, fill-FSM state encoding and the
// mask that turns a byte address into its block base.
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS     = 4;
    localparam int WORD_SEL_BITS   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Clears the byte offset within a 16-byte block; callers slice to ADDR_W.
    localparam logic [31:0] BLOCK_BASE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

endpackage

// File: rtl/word_decoder_3to8.sv
// 3-to-8 one-hot word select with enable; shared by the fill path and the
// controller's read-hit word selection.
module word_decoder_3to8 (
    input  logic [2:0] index,
    input  logic       enable,
    output logic [7:0] onehot
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sel
            assign onehot[gi] = enable && (index == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: issues one word read per cycle for the missing
// block and steers the in-order returns into the data array, then writes the tag.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [7:0]        fill_word_enable,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array,
    output logic              fill_done
);

    fill_state_t              state_reg;
    logic [ADDR_W-1:0]        base_reg;
    logic [WORD_SEL_BITS:0]   req_cnt_reg;
    logic [WORD_SEL_BITS-1:0] rsp_cnt_reg;

    logic in_fill;
    logic accept;
    logic last_word;

    always_comb begin
        in_fill   = (state_reg == FILL);
        // A word is only ours if a request for it has already left the FSM.
        accept    = in_fill && memory_data_valid &&
                    ({1'b0, rsp_cnt_reg} < req_cnt_reg);
        last_word = (rsp_cnt_reg == WORD_SEL_BITS'(WORDS - 1));

        fsm_busy         = in_fill;
        mem_read_en      = in_fill && (req_cnt_reg < (WORD_SEL_BITS + 1)'(WORDS));
        memory_address   = in_fill ? base_reg + ADDR_W'({req_cnt_reg[WORD_SEL_BITS-1:0], 1'b0})
                                   : '0;
        write_data_array = accept;
        write_tag_array  = accept && last_word;
        fill_done        = accept && last_word;
        fill_data        = memory_data;
    end

    word_decoder_3to8 u_word_decoder (
        .index  (rsp_cnt_reg),
        .enable (accept),
        .onehot (fill_word_enable)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            base_reg    <= '0;
            req_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_detected) begin
                        base_reg    <= miss_address & BLOCK_BASE_MASK[ADDR_W-1:0];
                        req_cnt_reg <= '0;
                        rsp_cnt_reg <= '0;
                        state_reg   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_read_en) begin
                        req_cnt_reg <= req_cnt_reg + 1'b1;
                    end
                    if (accept) begin
                        rsp_cnt_reg <= rsp_cnt_reg + 1'b1;
                        if (last_word) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a directed vector table, hand-built
// corner sequences and randomized fills against a pipelined-memory reference.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [7:0]  fill_word_enable;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic        fill_done;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_enable  (fill_word_enable),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference: a fill is "which block", "how many words asked for", "how many landed".
    bit          m_fill;
    logic [15:0] m_base;
    int          m_req;
    int          m_rsp;
    int          cyc;
    int          latency;
    int          gap_mode;
    logic [15:0] q_addr[$];
    int          q_time[$];

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] data;
        logic        e_busy;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_wr;
        logic [7:0]  e_we;
        logic        e_tag;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, fsm_busy, 0);
        chk({tag, "_rd"}, mem_read_en, 0);
        chk({tag, "_addr"}, memory_address, 0);
        chk({tag, "_wr"}, write_data_array, 0);
        chk({tag, "_we"}, fill_word_enable, 0);
        chk({tag, "_tag"}, write_tag_array, 0);
        chk({tag, "_done"}, fill_done, 0);
    endtask

    // One clock of traffic: memory emulator drives returns, DUT is compared to the model.
    task automatic step(input logic miss, input logic [15:0] maddr, input logic spurious);
        logic        v;
        logic [15:0] d;
        logic        gap_ok;
        logic        e_rd, e_wr, e_tag;
        logic [15:0] e_addr;
        logic [7:0]  e_we;
        @(negedge clk);
        v = 1'b0;
        d = 16'($urandom);
        case (gap_mode)
            1:       gap_ok = (cyc % 2 == 0);
            2:       gap_ok = ($urandom_range(0, 2) != 0);
            default: gap_ok = 1'b1;
        endcase
        if (spurious) begin
            v = 1'b1;
        end else if (q_addr.size() > 0 && q_time[0] <= cyc && gap_ok) begin
            v = 1'b1;
            d = mem_word(q_addr.pop_front());
            void'(q_time.pop_front());
        end
        miss_detected     = miss;
        miss_address      = maddr;
        memory_data_valid = v;
        memory_data       = d;
        #1;
        e_rd   = m_fill && (m_req < 8);
        e_addr = m_base + 16'(2 * m_req);
        e_wr   = m_fill && v && (m_rsp < m_req);
        e_we   = e_wr ? 8'(1 << m_rsp) : 8'h00;
        e_tag  = e_wr && (m_rsp == 7);
        chk("busy", fsm_busy, m_fill);
        chk("rd_en", mem_read_en, e_rd);
        if (e_rd) chk("rd_addr", memory_address, e_addr);
        chk("wr", write_data_array, e_wr);
        chk("word_en", fill_word_enable, e_we);
        chk("tag", write_tag_array, e_tag);
        chk("done", fill_done, e_tag);
        chk("fill_data", fill_data, d);
        if (e_wr) chk("word_order", fill_data, mem_word(m_base + 16'(2 * m_rsp)));
        $display("cyc %0d miss=%b v=%b busy=%b rd=%b addr=%h wr=%b we=%h tag=%b",
                 cyc, miss, v, fsm_busy, mem_read_en, memory_address,
                 write_data_array, fill_word_enable, write_tag_array);
        if (e_rd) begin
            q_addr.push_back(e_addr);
            q_time.push_back(cyc + latency);
        end
        @(posedge clk);
        if (!m_fill) begin
            if (miss) begin
                m_fill = 1'b1;
                m_base = maddr & 16'hFFF0;
                m_req  = 0;
                m_rsp  = 0;
            end
        end else begin
            if (e_rd) m_req++;
            if (e_wr) begin
                if (m_rsp == 7) m_fill = 1'b0;
                m_rsp++;
            end
        end
        cyc++;
    endtask

    // Start a fill then run it to completion; toggle_miss wiggles miss with alt_addr meanwhile.
    task automatic run_fill(input logic [15:0] addr, input bit toggle_miss, input logic [15:0] alt_addr);
        int k;
        step(1'b1, addr, 1'b0);
        for (k = 0; k < 300 && m_fill; k++) begin
            step(toggle_miss ? logic'(k % 2) : 1'b0, toggle_miss ? alt_addr : 16'h0, 1'b0);
        end
        if (m_fill) begin
            errors++;
            checks++;
            $display("FAIL fill_timeout at cycle %0d: busy=%b expected completion", cyc, fsm_busy);
        end
    endtask

    task automatic async_reset_now();
        @(negedge clk);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        chk("pre_reset_busy", fsm_busy, m_fill);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_fill = 1'b0;
        m_req  = 0;
        m_rsp  = 0;
        q_addr.delete();
        q_time.delete();
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        m_fill = 1'b0; m_base = 16'h0; m_req = 0; m_rsp = 0;
        cyc = 0; latency = 4; gap_mode = 0;

        // Expected waveform for a miss at 0x1236 with memory latency 4.
        for (int i = 0; i < 14; i++) begin
            tbl[i].miss   = (i == 0);
            tbl[i].addr   = (i == 0) ? 16'h1236 : 16'h0000;
            tbl[i].valid  = (i >= 5) && (i <= 12);
            tbl[i].data   = 16'h1000 + 16'(i);
            tbl[i].e_busy = (i >= 1) && (i <= 12);
            tbl[i].e_rd   = (i >= 1) && (i <= 8);
            tbl[i].e_addr = tbl[i].e_rd ? 16'h1230 + 16'(2 * (i - 1)) : 16'h0000;
            tbl[i].e_wr   = tbl[i].valid;
            tbl[i].e_we   = tbl[i].valid ? 8'(1 << (i - 5)) : 8'h00;
            tbl[i].e_tag  = (i == 12);
        end

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            miss_detected     = tbl[i].miss;
            miss_address      = tbl[i].addr;
            memory_data_valid = tbl[i].valid;
            memory_data       = tbl[i].data;
            #1;
            chk("tbl_busy", fsm_busy, tbl[i].e_busy);
            chk("tbl_rd", mem_read_en, tbl[i].e_rd);
            if (tbl[i].e_rd) chk("tbl_addr", memory_address, tbl[i].e_addr);
            chk("tbl_wr", write_data_array, tbl[i].e_wr);
            chk("tbl_we", fill_word_enable, tbl[i].e_we);
            chk("tbl_tag", write_tag_array, tbl[i].e_tag);
            chk("tbl_done", fill_done, tbl[i].e_tag);
            chk("tbl_data", fill_data, tbl[i].data);
            $display("vec %0d busy=%b rd=%b addr=%h wr=%b we=%h tag=%b", i, fsm_busy,
                     mem_read_en, memory_address, write_data_array, fill_word_enable, write_tag_array);
            @(posedge clk);
        end

        // Gapped returns, every other cycle.
        gap_mode = 1; latency = 4;
        run_fill(16'h1236, 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b0);

        // Miss wiggled with another block during the fill, then a fill from that block.
        gap_mode = 0; latency = 3;
        run_fill(16'h1236, 1'b1, 16'hABC0);
        if (m_fill) begin
            for (int k = 0; k < 300 && m_fill; k++) step(1'b0, 16'h0, 1'b0);
        end
        run_fill(16'hABC0, 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b0);

        // Stray valids in IDLE and in the first FILL cycle before any request exists.
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h2008, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 300 && m_fill; k++) step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        // Reset after the third word lands, then a clean fill at 0x0010.
        latency = 2;
        step(1'b1, 16'h1236, 1'b0);
        for (int k = 0; k < 100 && m_rsp < 3; k++) step(1'b0, 16'h0, 1'b0);
        async_reset_now();
        step(1'b0, 16'h0, 1'b0);
        latency = 1;
        run_fill(16'h0010, 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b0);

        // Randomized fills: random block, latency, gaps and mid-fill miss noise.
        gap_mode = 2;
        for (int n = 0; n < 20; n++) begin
            latency = $urandom_range(1, 6);
            run_fill(16'($urandom), logic'($urandom_range(0, 1)), 16'($urandom));
            for (int k = 0; k < 300 && m_fill; k++) step(1'b0, 16'h0, 1'b0);
            step(1'b0, 16'h0, logic'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
